bin_seg_display: RTL and testbench



---
 rtl/bin_seg_display.sv | 162 ++++++++++++++++
 tb/tb_bin_seg_display.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bin_seg_display.sv
// rtl/bin_seg_display.sv - Time-multiplexed seven-segment driver with sequential binary-to-BCD conversion
module bin_seg_display #(
  parameter int DIGITS   = 4,
  parameter int WIDTH    = 14,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOAD,
  input  logic [WIDTH-1:0]  VALUE,
  output logic              BUSY,
  output logic              OVF,
  output logic [6:0]        SEG,
  output logic [DIGITS-1:0] AN
);

  localparam int BW = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   bin;
  logic [BW-1:0]      bcd;
  logic [BW-1:0]      bcd_adj;
  logic [SW-1:0]      step;
  logic               ovf_pend;
  logic [BW-1:0]      disp;
  logic [PW-1:0]      presc;
  logic [IW-1:0]      idx;
  logic [3:0]         cur;
  logic               upper_zero;
  logic               blank;
  logic [6:0]         seg_next;
  logic [DIGITS-1:0]  an_next;

  assign BUSY = (state != IDLE);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: LOAD only honoured in IDLE, WIDTH conversion steps, then one commit cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (LOAD) state_next = CONV;
      CONV:    if (step == SW'(WIDTH - 1)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction of every BCD nibble that is 5 or more, ahead of the shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Conversion datapath; display registers only change on commit so partial results never show
  always_ff @(posedge CLK) begin
    if (RST) begin
      bin      <= '0;
      bcd      <= '0;
      step     <= '0;
      ovf_pend <= 1'b0;
      disp     <= '0;
      OVF      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (LOAD) begin
            bin      <= VALUE;
            bcd      <= '0;
            step     <= '0;
            ovf_pend <= (64'(VALUE) >= LIMIT);
          end
        end
        CONV: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          step       <= step + SW'(1);
        end
        COMMIT: begin
          disp <= bcd;
          OVF  <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

  // Pick the scanned digit and decide dash / blank / numeral for it
  always_comb begin
    cur        = 4'd0;
    upper_zero = 1'b1;
    blank      = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx) cur = disp[4*i +: 4];
    end
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (disp[4*i +: 4] != 4'd0) upper_zero = 1'b0;
      if (IW'(i) == idx && upper_zero) blank = 1'b1;
    end
    if (OVF)                          seg_next = 7'b0111111;
    else if (blank && BLANK_LZ != 0)  seg_next = 7'b1111111;
    else                              seg_next = enc(cur);
    an_next = ~(DIGITS'(1) << idx);
  end

  // Scan prescaler, digit index and registered pin drive
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc <= '0;
      idx   <= '0;
      SEG   <= 7'h7F;
      AN    <= '1;
    end else begin
      if (presc == PW'(SCAN_DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
      SEG <= seg_next;
      AN  <= an_next;
    end
  end

endmodule

// File: tb/tb_bin_seg_display.sv
// tb/tb_bin_seg_display.sv - Randomized self-checking bench for bin_seg_display
module tb_bin_seg_display;

  localparam int DIGITS   = 4;
  localparam int WIDTH    = 14;
  localparam int SCAN_DIV = 4;

  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] value;
  logic             busy, busy_nb;
  logic             ovf, ovf_nb;
  logic [6:0]       seg, seg_nb;
  logic [3:0]       an, an_nb;

  int n_checks = 0;
  int n_pass   = 0;

  bin_seg_display #(.DIGITS(DIGITS), .WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)) dut (
    .CLK(clk), .RST(rst), .LOAD(load), .VALUE(value),
    .BUSY(busy), .OVF(ovf), .SEG(seg), .AN(an)
  );

  bin_seg_display #(.DIGITS(DIGITS), .WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(0)) dut_nb (
    .CLK(clk), .RST(rst), .LOAD(load), .VALUE(value),
    .BUSY(busy_nb), .OVF(ovf_nb), .SEG(seg_nb), .AN(an_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int p10(input int n);
    int r;
    r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] digit_pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference: what digit position pos should show for a committed value v
  function automatic logic [6:0] exp_seg(input int v, input int pos, input bit blz);
    if (v >= p10(DIGITS)) return 7'b0111111;
    if (blz && pos > 0 && v < p10(pos)) return 7'b1111111;
    return digit_pat((v / p10(pos)) % 10);
  endfunction

  function automatic int an_index(input logic [3:0] a);
    int r;
    r = -1;
    for (int i = 0; i < DIGITS; i++) if (a == ~(4'b0001 << i)) r = i;
    return r;
  endfunction

  // One full scan round on both instances, checked digit by digit against the model
  task automatic check_display(input int v, input string tag);
    int ix, ixn;
    for (int c = 0; c < DIGITS * SCAN_DIV; c++) begin
      @(negedge clk);
      ix  = an_index(an);
      ixn = an_index(an_nb);
      check({tag, "_an"}, (ix >= 0) ? 32'd1 : 32'd0, 32'd1);
      if (ix >= 0) check({tag, "_seg"}, {25'd0, seg}, {25'd0, exp_seg(v, ix, 1'b1)});
      if (ixn >= 0) check({tag, "_seg_nolz"}, {25'd0, seg_nb}, {25'd0, exp_seg(v, ixn, 1'b0)});
      else check({tag, "_an_nolz"}, 32'd0, 32'd1);
    end
  endtask

  // Pulse LOAD and count the cycles BUSY stays high, bounded
  task automatic load_and_wait(input int v, output int busy_cycles);
    @(negedge clk);
    load  = 1'b1;
    value = WIDTH'(v);
    @(negedge clk);
    load = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 200) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic run_value(input int v, input string tag);
    int bc;
    load_and_wait(v, bc);
    check({tag, "_busy_len"}, bc, WIDTH + 1);
    check({tag, "_ovf"}, {31'd0, ovf}, (v >= p10(DIGITS)) ? 32'd1 : 32'd0);
    check_display(v, tag);
  endtask

  initial begin
    int ix, bc, v;
    rst   = 1'b1;
    load  = 1'b0;
    value = '0;
    repeat (3) @(negedge clk);
    check("rst_seg",  {25'd0, seg}, 32'h7F);
    check("rst_an",   {28'd0, an}, 32'hF);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf",  {31'd0, ovf}, 32'd0);
    rst = 1'b0;

    // Scan order and dwell after reset: each digit for SCAN_DIV cycles
    for (int k = 0; k < 2 * DIGITS * SCAN_DIV; k++) begin
      @(negedge clk);
      ix = (k / SCAN_DIV) % DIGITS;
      check("scan_an",  {28'd0, an}, {28'd0, ~(4'b0001 << ix)});
      check("scan_seg", {25'd0, seg}, {25'd0, exp_seg(0, ix, 1'b1)});
    end

    run_value(1234, "v1234");
    run_value(10000, "v10000");
    run_value(9999, "v9999");
    run_value(907, "v907");
    run_value(0, "v0");
    run_value(16383, "vmax");

    // Second LOAD while busy must be dropped
    @(negedge clk);
    load = 1'b1; value = WIDTH'(8);
    @(negedge clk);
    load = 1'b0;
    bc = 0;
    repeat (2) begin
      if (busy) bc++;
      @(negedge clk);
    end
    load = 1'b1; value = WIDTH'(5);
    if (busy) bc++;
    @(negedge clk);
    load = 1'b0;
    while (busy && bc < 200) begin
      bc++;
      @(negedge clk);
    end
    check("drop_busy_len", bc, WIDTH + 1);
    check_display(8, "drop");

    // Reset during conversion aborts and restores reset values
    @(negedge clk);
    load = 1'b1; value = WIDTH'(42);
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ovf",  {31'd0, ovf}, 32'd0);
    check("mid_rst_seg",  {25'd0, seg}, 32'h7F);
    check("mid_rst_an",   {28'd0, an}, 32'hF);
    rst = 1'b0;
    check_display(0, "after_rst");
    run_value(42, "v42_after_rst");

    // Randomized values, mixing small numbers (leading-zero blanking) and overflow
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 2))
        0:       v = int'($urandom_range(0, 99));
        1:       v = int'($urandom_range(0, 9999));
        default: v = int'($urandom_range(0, 16383));
      endcase
      run_value(v, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
